// File: rtl/pla_pkg.sv
// Shared types and sizing for the programmable AND-OR array.
// PLA_INVERT_EN appends a per-output invert mask to the configuration stream.
package pla_pkg;

   typedef enum logic [1:0] {
      UNCFG  = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      ACTIVE = 2'd3
   } cfg_state_e;

   function automatic int cfg_bits(input int n_in, input int n_terms, input int n_out);
`ifdef PLA_INVERT_EN
      return n_terms * n_in + n_out * n_terms + n_out;
`else
      return n_terms * n_in + n_out * n_terms;
`endif
   endfunction

endpackage

// File: rtl/pla_cfg_loader.sv
// Serial configuration loader: shifts a bit stream into a shadow register and
// commits it atomically to the active mask vector.
module pla_cfg_loader
   import pla_pkg::*;
#(
   parameter int N_IN    = 6,
   parameter int N_TERMS = 4,
   parameter int N_OUT   = 2,
   parameter int CFG_W   = cfg_bits(N_IN, N_TERMS, N_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_loaded,
   output logic [CFG_W-1:0] active_cfg
);

   localparam int CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_W - 1);

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CFG_W-1:0] active_q, active_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             loaded_q, loaded_d;

   // Next-state logic; the active copy is taken on the edge that accepts the final bit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      done_d   = 1'b0;
      loaded_d = loaded_q;
      case (state_q)
         UNCFG, ACTIVE: begin
            if (cfg_start) begin
               state_d  = LOAD;
               cnt_d    = {CNT_W{1'b0}};
               shadow_d = {CFG_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            if (cfg_start) begin
               cnt_d    = {CNT_W{1'b0}};
               shadow_d = {CFG_W{1'b0}};
            end else if (cfg_valid) begin
               // Shift right so the first bit received lands in bit 0.
               shadow_d = {cfg_bit, shadow_q[CFG_W-1:1]};
               if (cnt_q == LAST_IDX) begin
                  state_d  = COMMIT;
                  cnt_d    = {CNT_W{1'b0}};
                  active_d = shadow_d;
                  done_d   = 1'b1;
                  loaded_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = state_q;
            end
         end
         COMMIT: begin
            state_d = ACTIVE;
         end
         default: begin
            state_d = UNCFG;
         end
      endcase
      ready_d = (state_d == LOAD);
   end

   // Loader state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= UNCFG;
         cnt_q    <= {CNT_W{1'b0}};
         shadow_q <= {CFG_W{1'b0}};
         active_q <= {CFG_W{1'b0}};
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         loaded_q <= loaded_d;
      end
   end

   assign cfg_ready  = ready_q;
   assign cfg_done   = done_q;
   assign cfg_loaded = loaded_q;
   assign active_cfg = active_q;

endmodule

// File: rtl/pla_and_or.sv
// Field-programmable AND-OR array with a registered one-cycle evaluation stage.
// Define PLA_INVERT_EN to make each output AND-OR-INVERT under a configurable mask.
module pla_and_or
   import pla_pkg::*;
#(
   parameter int N_IN    = 6,
   parameter int N_TERMS = 4,
   parameter int N_OUT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N_IN-1:0]  in_data,
   output logic             out_valid,
   output logic [N_OUT-1:0] out_data,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_loaded
);

   localparam int CFG_W   = cfg_bits(N_IN, N_TERMS, N_OUT);
   localparam int OR_BASE = N_TERMS * N_IN;
`ifdef PLA_INVERT_EN
   localparam int INV_BASE = OR_BASE + N_OUT * N_TERMS;
`endif

   logic [CFG_W-1:0]   active_s;
   logic [N_IN-1:0]    and_m_s;
   logic [N_TERMS-1:0] or_m_s;
   logic [N_TERMS-1:0] term_s;
   logic [N_OUT-1:0]   eval_s;

   logic               out_valid_q, out_valid_d;
   logic [N_OUT-1:0]   out_data_q, out_data_d;

   pla_cfg_loader #(
      .N_IN    (N_IN),
      .N_TERMS (N_TERMS),
      .N_OUT   (N_OUT),
      .CFG_W   (CFG_W)
   ) u_loader (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .cfg_loaded (cfg_loaded),
      .active_cfg (active_s)
   );

   // Product terms and OR plane; an empty AND mask disables its term.
   always_comb begin
      and_m_s = {N_IN{1'b0}};
      or_m_s  = {N_TERMS{1'b0}};
      term_s  = {N_TERMS{1'b0}};
      eval_s  = {N_OUT{1'b0}};
      for (int t = 0; t < N_TERMS; t++) begin
         and_m_s   = active_s[t*N_IN +: N_IN];
         term_s[t] = (|and_m_s) & ((in_data & and_m_s) == and_m_s);
      end
      for (int o = 0; o < N_OUT; o++) begin
         or_m_s    = active_s[OR_BASE + o*N_TERMS +: N_TERMS];
         eval_s[o] = |(term_s & or_m_s);
      end
`ifdef PLA_INVERT_EN
      eval_s = eval_s ^ active_s[INV_BASE +: N_OUT];
`endif
   end

   // Output stage; data holds its last value while no input is valid.
   always_comb begin
      out_valid_d = in_valid;
      if (in_valid) begin
         out_data_d = eval_s;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {N_OUT{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_pla_and_or.sv
// Self-checking bench for pla_and_or: behavioural model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_pla_and_or;

   localparam int N_IN    = 6;
   localparam int N_TERMS = 4;
   localparam int N_OUT   = 2;
`ifdef PLA_INVERT_EN
   localparam int NB = N_TERMS * N_IN + N_OUT * N_TERMS + N_OUT;
   localparam logic [1:0] INV_A = 2'b10;
   localparam logic [NB-1:0] IMG_A = {2'b10, 4'b1100, 4'b0011,
                                      6'b001100, 6'b000011, 6'b111000, 6'b000111};
   localparam logic [NB-1:0] IMG_B = {2'b00, 4'b1010, 4'b0101,
                                      6'b111111, 6'b000000, 6'b010010, 6'b100001};
`else
   localparam int NB = N_TERMS * N_IN + N_OUT * N_TERMS;
   localparam logic [1:0] INV_A = 2'b00;
   localparam logic [NB-1:0] IMG_A = {4'b1100, 4'b0011,
                                      6'b001100, 6'b000011, 6'b111000, 6'b000111};
   localparam logic [NB-1:0] IMG_B = {4'b1010, 4'b0101,
                                      6'b111111, 6'b000000, 6'b010010, 6'b100001};
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [N_IN-1:0]  in_data = '0;
   logic             out_valid;
   logic [N_OUT-1:0] out_data;
   logic             cfg_start = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_bit = 1'b0;
   logic             cfg_ready;
   logic             cfg_done;
   logic             cfg_loaded;

   int checks = 0;
   int errors = 0;
   int done_pulses = 0;

   pla_and_or dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .cfg_loaded (cfg_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N_IN-1:0]    m_and [N_TERMS];
   logic [N_TERMS-1:0] m_or  [N_OUT];
   logic [N_OUT-1:0]   m_inv;
   bit                 m_bits[$];
   bit                 m_loading, m_commit_cyc, m_loaded;
   logic               exp_valid = 1'b0, exp_ready = 1'b0, exp_done = 1'b0, exp_loaded = 1'b0;
   logic [N_OUT-1:0]   exp_data = '0;

   function automatic logic [N_OUT-1:0] m_eval(input logic [N_IN-1:0] x);
      logic [N_OUT-1:0] r;
      for (int o = 0; o < N_OUT; o++) begin
         r[o] = 1'b0;
         for (int t = 0; t < N_TERMS; t++)
            if (m_or[o][t] && m_and[t] != 0 && (x & m_and[t]) == m_and[t]) r[o] = 1'b1;
         r[o] = r[o] ^ m_inv[o];
      end
      return r;
   endfunction

   task automatic m_reset();
      for (int t = 0; t < N_TERMS; t++) m_and[t] = '0;
      for (int o = 0; o < N_OUT; o++) m_or[o] = '0;
      m_inv = '0;
      m_bits.delete();
      m_loading = 0; m_commit_cyc = 0; m_loaded = 0;
      exp_valid = 0; exp_data = '0; exp_ready = 0; exp_done = 0; exp_loaded = 0;
   endtask

   task automatic m_decode();
      for (int t = 0; t < N_TERMS; t++)
         for (int i = 0; i < N_IN; i++) m_and[t][i] = m_bits[t*N_IN + i];
      for (int o = 0; o < N_OUT; o++)
         for (int t = 0; t < N_TERMS; t++) m_or[o][t] = m_bits[N_TERMS*N_IN + o*N_TERMS + t];
`ifdef PLA_INVERT_EN
      for (int o = 0; o < N_OUT; o++) m_inv[o] = m_bits[N_TERMS*N_IN + N_OUT*N_TERMS + o];
`endif
   endtask

   task automatic m_step();
      logic [N_OUT-1:0] nd;
      bit done_now;
      done_now = 0;
      nd = in_valid ? m_eval(in_data) : exp_data;
      if (m_commit_cyc) begin
         m_commit_cyc = 0;
      end else if (cfg_start) begin
         m_bits.delete();
         m_loading = 1;
      end else if (m_loading && cfg_valid) begin
         m_bits.push_back(cfg_bit);
         if (m_bits.size() == NB) begin
            m_decode();
            m_loading = 0; m_loaded = 1; done_now = 1; m_commit_cyc = 1;
         end
      end
      exp_valid = in_valid; exp_data = nd; exp_done = done_now;
      exp_ready = m_loading; exp_loaded = m_loaded;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         #1;
         chk("cyc_out_valid", 32'(out_valid), 32'(exp_valid));
         chk("cyc_out_data", 32'(out_data), 32'(exp_data));
         chk("cyc_cfg_ready", 32'(cfg_ready), 32'(exp_ready));
         chk("cyc_cfg_done", 32'(cfg_done), 32'(exp_done));
         chk("cyc_cfg_loaded", 32'(cfg_loaded), 32'(exp_loaded));
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cfg_done === 1'b1) done_pulses++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic start_load();
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; cfg_valid = 1'b0;
      chk("ready_after_start", 32'(cfg_ready), 32'd1);
   endtask

   task automatic send_bits(input logic [NB-1:0] img, input int from, input int to);
      for (int k = from; k < to; k++) begin
         cfg_valid = 1'b1;
         cfg_bit   = img[k];
         @(negedge clk);
      end
      cfg_valid = 1'b0;
   endtask

   task automatic apply(input logic [N_IN-1:0] x, input logic [N_OUT-1:0] e, input string name);
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      chk(name, 32'(out_data), 32'(e));
      chk({name, "_vld"}, 32'(out_valid), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [NB-1:0] img_v;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_cfg_loaded", 32'(cfg_loaded), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // unconfigured array evaluates to zero
      apply(6'b111111, 2'b00, "uncfg_111111");
      chk("uncfg_loaded", 32'(cfg_loaded), 32'd0);
      @(negedge clk);
      chk("idle_valid_low", 32'(out_valid), 32'd0);

      // program image A
      start_load();
      send_bits(IMG_A, 0, NB);
      chk("a_done", 32'(cfg_done), 32'd1);
      chk("a_loaded", 32'(cfg_loaded), 32'd1);
      apply(6'b111000, 2'b01 ^ INV_A, "a_111000");
      apply(6'b001100, 2'b10 ^ INV_A, "a_001100");
      apply(6'b000111, 2'b11 ^ INV_A, "a_000111");
      apply(6'b000000, 2'b00 ^ INV_A, "a_000000");

      // image B, with inputs straddling the commit edge
      start_load();
      send_bits(IMG_B, 0, NB - 1);
      img_v     = IMG_B;
      cfg_valid = 1'b1;
      cfg_bit   = img_v[NB-1];
      in_valid  = 1'b1;
      in_data   = 6'b100001;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("straddle_old", 32'(out_data), 32'(2'b00 ^ INV_A));
      chk("straddle_done", 32'(cfg_done), 32'd1);
      @(negedge clk);
      chk("straddle_new", 32'(out_data), 32'(2'b01));
      in_valid = 1'b0;
      apply(6'b000000, 2'b00, "b_zero_mask_term");
      apply(6'b010010, 2'b10, "b_010010");
      apply(6'b111111, 2'b11, "b_111111");

      // restart mid-load: partial B discarded, full A committed once
      done_pulses = 0;
      start_load();
      send_bits(IMG_B, 0, 10);
      start_load();
      send_bits(IMG_A, 0, NB);
      repeat (3) @(negedge clk);
      chk("restart_done_pulses", 32'(done_pulses), 32'd1);
      apply(6'b111000, 2'b01 ^ INV_A, "restart_a_111000");
      apply(6'b100001, 2'b00 ^ INV_A, "restart_a_100001");

      // reset in the middle of a load and of an evaluation
      start_load();
      send_bits(IMG_B, 0, 20);
      in_valid = 1'b1;
      in_data  = 6'b111111;
      rst_n    = 1'b0;
      #2;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("midrst_cfg_done", 32'(cfg_done), 32'd0);
      chk("midrst_cfg_loaded", 32'(cfg_loaded), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      apply(6'b111000, 2'b00, "postrst_111000");
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("postrst_ready", 32'(cfg_ready), 32'd0);

      // reload A; done only after the full stream length
      start_load();
      send_bits(IMG_A, 0, NB - 1);
      chk("final_not_done_early", 32'(cfg_done), 32'd0);
      send_bits(IMG_A, NB - 1, NB);
      chk("final_done", 32'(cfg_done), 32'd1);
      apply(6'b111000, 2'b01 ^ INV_A, "final_a_111000");
      apply(6'b000111, 2'b11 ^ INV_A, "final_a_000111");
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
